// File: rtl/line_sensor_pkg.sv
// line_sensor_pkg: shared FSM encoding, default parameters and channel indices for the line sensor reader
//   CHARGE/MEASURE/EVAL  frame sequencer states
//   DEF_*                default sizing and timing constants
//   LEFT/MIDDLE/RIGHT    bit positions of each sensor in 3-bit vectors
package line_sensor_pkg;

    typedef enum logic [1:0] {
        CHARGE,
        MEASURE,
        EVAL
    } state_t;

    localparam int DEF_CNT_W         = 18;
    localparam int DEF_CHARGE_CYCLES = 500;
    localparam int DEF_TIMEOUT       = 150000;
    localparam int DEF_THRESHOLD     = 50000;
    localparam int DEF_FILTER_DEPTH  = 4;

    localparam int LEFT   = 2;
    localparam int MIDDLE = 1;
    localparam int RIGHT  = 0;

endpackage

// File: rtl/line_sensor_debounce.sv
// line_sensor_debounce: per-channel streak filter; filtered flips only after FILTER_DEPTH consecutive disagreeing samples
//   clk, reset  clock and asynchronous active-high reset (filtered resets to 1)
//   update      one-cycle strobe qualifying raw
//   raw         new thresholded sample
//   filtered    debounced bit
module line_sensor_debounce
    import line_sensor_pkg::*;
#(
    parameter int FILTER_DEPTH = DEF_FILTER_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic update,
    input  logic raw,
    output logic filtered
);

    localparam int SW = $clog2(FILTER_DEPTH + 1);

    logic [SW-1:0] streak;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filtered <= 1'b1;
            streak   <= '0;
        end else if (update) begin
            if (raw == filtered) begin
                streak <= '0;
            end else if (streak == SW'(FILTER_DEPTH - 1)) begin
                filtered <= raw;
                streak   <= '0;
            end else begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_sensor_reader.sv
// line_sensor_reader: charges three RC reflectance sensors, times their decay, thresholds and debounces the result
//   clk, reset            clock and asynchronous active-high reset
//   sensor_in[2:0]        pad inputs (left, middle, right), asynchronous to clk
//   sensor_drive[2:0]     pad drive-high enables, 0 releases the pad
//   sensor*Filtered       debounced bits (1 = bright, 0 = line)
//   raw_bits[2:0]         undebounced bits of the last frame
//   count_l/m/r           last captured decay counts
//   sample_valid          one-cycle pulse when the outputs above update
module line_sensor_reader
    import line_sensor_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int CHARGE_CYCLES = DEF_CHARGE_CYCLES,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    parameter int THRESHOLD     = DEF_THRESHOLD,
    parameter int FILTER_DEPTH  = DEF_FILTER_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       sensor_in,
    output logic [2:0]       sensor_drive,
    output logic             sensorLeftFiltered,
    output logic             sensorMiddleFiltered,
    output logic             sensorRightFiltered,
    output logic [2:0]       raw_bits,
    output logic [CNT_W-1:0] count_l,
    output logic [CNT_W-1:0] count_m,
    output logic [CNT_W-1:0] count_r,
    output logic             sample_valid
);

    localparam int CHG_W = $clog2(CHARGE_CYCLES + 1);

    state_t           state, nextState;
    logic [2:0]       syncA, syncB;
    logic [CHG_W-1:0] chargeCnt;
    logic [CNT_W-1:0] measCnt;
    logic [2:0]       done, doneNext;
    logic             measEnd;
    logic [2:0]       raw;
    logic [CNT_W-1:0] cap [3];
    logic             evalStrobe;

    assign evalStrobe = (state == EVAL);

    // The drive is gated by reset directly so the pads are released the
    // moment reset rises, even though the state register resets to CHARGE.
    always_comb begin
        nextState    = state;
        sensor_drive = 3'b000;
        doneNext     = done | ~syncB;
        measEnd      = (&doneNext) || (measCnt == CNT_W'(TIMEOUT - 1));
        for (int i = 0; i < 3; i++) raw[i] = cap[i] < CNT_W'(THRESHOLD);
        case (state)
            CHARGE: begin
                sensor_drive = reset ? 3'b000 : 3'b111;
                nextState    = (chargeCnt == CHG_W'(CHARGE_CYCLES - 1)) ? MEASURE : CHARGE;
            end
            MEASURE: nextState = measEnd ? EVAL : MEASURE;
            default: nextState = CHARGE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= CHARGE;
            syncA        <= 3'b111;
            syncB        <= 3'b111;
            chargeCnt    <= '0;
            measCnt      <= '0;
            done         <= '0;
            cap          <= '{default: '0};
            count_l      <= '0;
            count_m      <= '0;
            count_r      <= '0;
            raw_bits     <= 3'b111;
            sample_valid <= 1'b0;
        end else begin
            syncA        <= sensor_in;
            syncB        <= syncA;
            state        <= nextState;
            chargeCnt    <= (state == CHARGE) ? chargeCnt + 1'b1 : '0;
            measCnt      <= (state == MEASURE && !measEnd) ? measCnt + 1'b1 : '0;
            done         <= (state == MEASURE) ? doneNext : '0;
            sample_valid <= evalStrobe;
            // First low sample latches the count; channels still high when the
            // measurement closes saturate at TIMEOUT.
            if (state == MEASURE) begin
                for (int i = 0; i < 3; i++) begin
                    if (!done[i] && !syncB[i]) cap[i] <= measCnt;
                    else if (measEnd && !doneNext[i]) cap[i] <= CNT_W'(TIMEOUT);
                end
            end
            if (evalStrobe) begin
                count_l  <= cap[LEFT];
                count_m  <= cap[MIDDLE];
                count_r  <= cap[RIGHT];
                raw_bits <= raw;
            end
        end
    end

    line_sensor_debounce #(.FILTER_DEPTH(FILTER_DEPTH)) uDebLeft (
        .clk(clk), .reset(reset), .update(evalStrobe), .raw(raw[LEFT]), .filtered(sensorLeftFiltered)
    );

    line_sensor_debounce #(.FILTER_DEPTH(FILTER_DEPTH)) uDebMiddle (
        .clk(clk), .reset(reset), .update(evalStrobe), .raw(raw[MIDDLE]), .filtered(sensorMiddleFiltered)
    );

    line_sensor_debounce #(.FILTER_DEPTH(FILTER_DEPTH)) uDebRight (
        .clk(clk), .reset(reset), .update(evalStrobe), .raw(raw[RIGHT]), .filtered(sensorRightFiltered)
    );

endmodule

// File: tb/tb_line_sensor_reader.sv
// tb_line_sensor_reader: self-checking bench with an RC sensor model and a per-frame expectation queue
module tb_line_sensor_reader;

    localparam int CW = 18;
    localparam int CC = 4;
    localparam int TO = 100;
    localparam int TH = 40;
    localparam int FD = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    sensor_in = 3'b111;
    logic [2:0]    sensor_drive;
    logic          sensorLeftFiltered, sensorMiddleFiltered, sensorRightFiltered;
    logic [2:0]    raw_bits;
    logic [CW-1:0] count_l, count_m, count_r;
    logic          sample_valid;

    always #5 clk = ~clk;

    line_sensor_reader #(
        .CNT_W(CW), .CHARGE_CYCLES(CC), .TIMEOUT(TO), .THRESHOLD(TH), .FILTER_DEPTH(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sensor_in(sensor_in),
        .sensor_drive(sensor_drive),
        .sensorLeftFiltered(sensorLeftFiltered),
        .sensorMiddleFiltered(sensorMiddleFiltered),
        .sensorRightFiltered(sensorRightFiltered),
        .raw_bits(raw_bits),
        .count_l(count_l),
        .count_m(count_m),
        .count_r(count_r),
        .sample_valid(sample_valid)
    );

    // RC model: pads read high while driven; once released, a pad stays high
    // for its decay time (in cycles) and then reads low.
    int dl = 1000, dm = 1000, dr = 1000;
    int t = 0;

    always @(negedge clk) begin
        if (reset || sensor_drive != 3'b000) begin
            t = 0;
            sensor_in = 3'b111;
        end else begin
            sensor_in = {t < dl, t < dm, t < dr};
            t++;
        end
    end

    typedef struct packed {
        logic [CW-1:0] cl;
        logic [CW-1:0] cm;
        logic [CW-1:0] cr;
        logic [2:0]    raw;
        logic [2:0]    filt;
        logic [31:0]   period;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   mf[3] = '{1, 1, 1};
    int   ms[3] = '{0, 0, 0};

    wire [2:0]  filt = {sensorLeftFiltered, sensorMiddleFiltered, sensorRightFiltered};
    wire [59:0] got  = {count_l, count_m, count_r, raw_bits, filt};

    // Expected frame from decay times: count includes 2 cycles of sync latency,
    // saturates at TO, and measure ends one cycle after the last capture.
    function automatic void push_frame(int a, int b, int c);
        int            d[3];
        logic [CW-1:0] k[3];
        logic [2:0]    r;
        bit            all;
        int            mx;
        exp_t          e;
        d[2] = a; d[1] = b; d[0] = c;
        all = 1'b1;
        mx = 0;
        for (int i = 0; i < 3; i++) begin
            if (d[i] + 2 <= TO - 1) begin
                k[i] = CW'(d[i] + 2);
                if (d[i] + 2 > mx) mx = d[i] + 2;
            end else begin
                k[i] = CW'(TO);
                all = 1'b0;
            end
            r[i] = (k[i] < CW'(TH));
            if (int'(r[i]) == mf[i]) ms[i] = 0;
            else begin
                ms[i]++;
                if (ms[i] == FD) begin
                    mf[i] = int'(r[i]);
                    ms[i] = 0;
                end
            end
        end
        e.cl = k[2]; e.cm = k[1]; e.cr = k[0];
        e.raw = r;
        e.filt = {mf[2][0], mf[1][0], mf[0][0]};
        e.period = 32'(CC + (all ? mx + 1 : TO) + 1);
        q.push_back(e);
    endfunction

    task automatic wait_sample(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sample_valid && cyc < 400);
    endtask

    task automatic count_charge(input string name);
        int n = 0;
        int bad = 0;
        #1;
        while (sensor_drive == 3'b111 && n < 50) begin
            if (sample_valid !== 1'b0 || filt !== 3'b111) bad++;
            n++;
            @(negedge clk);
        end
        compared++;
        if (n != CC || sensor_drive !== 3'b000) begin
            mismatched++;
            $display("FAIL %s_charge_len: drive-high cycles=%0d drive=%b, required %0d then 000", name, n, sensor_drive, CC);
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL %s_charge_outputs: %0d cycles with valid/filtered wrong, required valid=0 filtered=111", name, bad);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        compared++;
        if ({sensor_drive, filt, raw_bits, count_l, count_m, count_r, sample_valid} !== {3'b000, 3'b111, 3'b111, 54'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: drive=%b filt=%b raw=%b counts=%0d/%0d/%0d valid=%b, required 000 111 111 0/0/0 0",
                     sensor_drive, filt, raw_bits, count_l, count_m, count_r, sample_valid);
        end
        repeat (2) @(negedge clk);
        dl = 10; dm = 60; dr = 10;
        push_frame(10, 60, 10);
        reset = 1'b0;
        count_charge("reset");
    endtask

    task automatic test_pattern();
        int   cyc;
        exp_t e;
        for (int f = 0; f < 3; f++) begin
            if (f > 0) push_frame(10, 60, 10);
            wait_sample(cyc);
            compared++;
            if (!sample_valid) begin
                mismatched++;
                $display("FAIL pattern_pulse: no sample_valid within %0d cycles", cyc);
                return;
            end
            e = q.pop_front();
            compared++;
            if (got !== {e.cl, e.cm, e.cr, e.raw, e.filt}) begin
                mismatched++;
                $display("FAIL pattern_frame%0d: counts=%0d/%0d/%0d raw=%b filt=%b, required %0d/%0d/%0d %b %b",
                         f, count_l, count_m, count_r, raw_bits, filt, e.cl, e.cm, e.cr, e.raw, e.filt);
            end
            if (f > 0) begin
                compared++;
                if (cyc != int'(e.period)) begin
                    mismatched++;
                    $display("FAIL pattern_period%0d: %0d cycles, required %0d", f, cyc, e.period);
                end
            end
        end
        compared++;
        if (filt !== 3'b101) begin
            mismatched++;
            $display("FAIL pattern_filtered_flip: filt=%b, required 101", filt);
        end
    endtask

    task automatic test_saturate();
        int   cyc;
        exp_t e;
        dl = 10; dm = 1000; dr = 10;
        push_frame(10, 1000, 10);
        wait_sample(cyc);
        compared++;
        if (!sample_valid) begin
            mismatched++;
            $display("FAIL saturate_pulse: no sample_valid within %0d cycles", cyc);
            return;
        end
        e = q.pop_front();
        compared++;
        if (got !== {e.cl, e.cm, e.cr, e.raw, e.filt} || count_m !== CW'(TO) || raw_bits[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL saturate_frame: counts=%0d/%0d/%0d raw=%b filt=%b, required %0d/%0d/%0d %b %b",
                     count_l, count_m, count_r, raw_bits, filt, e.cl, e.cm, e.cr, e.raw, e.filt);
        end
        compared++;
        if (cyc != CC + TO + 1) begin
            mismatched++;
            $display("FAIL saturate_period: %0d cycles, required %0d", cyc, CC + TO + 1);
        end
    endtask

    task automatic test_early_end();
        int   cyc;
        exp_t e;
        dl = 5; dm = 5; dr = 5;
        for (int f = 0; f < 3; f++) begin
            push_frame(5, 5, 5);
            wait_sample(cyc);
            compared++;
            if (!sample_valid) begin
                mismatched++;
                $display("FAIL early_pulse: no sample_valid within %0d cycles", cyc);
                return;
            end
            e = q.pop_front();
            compared++;
            if (got !== {e.cl, e.cm, e.cr, e.raw, e.filt} || count_l !== 18'd7 || raw_bits !== 3'b111) begin
                mismatched++;
                $display("FAIL early_frame%0d: counts=%0d/%0d/%0d raw=%b filt=%b, required %0d/%0d/%0d %b %b",
                         f, count_l, count_m, count_r, raw_bits, filt, e.cl, e.cm, e.cr, e.raw, e.filt);
            end
            compared++;
            if (cyc != 13) begin
                mismatched++;
                $display("FAIL early_period%0d: %0d cycles, required 13", f, cyc);
            end
        end
    endtask

    task automatic test_glitch();
        int   cyc;
        exp_t e;
        int   seq[6] = '{60, 60, 5, 60, 60, 60};
        bit   fm[6]  = '{1, 1, 1, 1, 1, 0};
        dl = 5; dr = 5;
        for (int f = 0; f < 6; f++) begin
            dm = seq[f];
            push_frame(5, seq[f], 5);
            wait_sample(cyc);
            compared++;
            if (!sample_valid) begin
                mismatched++;
                $display("FAIL glitch_pulse: no sample_valid within %0d cycles", cyc);
                return;
            end
            e = q.pop_front();
            compared++;
            if (got !== {e.cl, e.cm, e.cr, e.raw, e.filt} || cyc != int'(e.period)) begin
                mismatched++;
                $display("FAIL glitch_frame%0d: counts=%0d/%0d/%0d raw=%b filt=%b period=%0d, required %0d/%0d/%0d %b %b %0d",
                         f, count_l, count_m, count_r, raw_bits, filt, cyc, e.cl, e.cm, e.cr, e.raw, e.filt, e.period);
            end
            compared++;
            if (sensorMiddleFiltered !== fm[f]) begin
                mismatched++;
                $display("FAIL glitch_middle%0d: filtered_m=%b, required %b", f, sensorMiddleFiltered, fm[f]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int   cyc = 0;
        int   bad = 0;
        exp_t e;
        @(negedge clk);
        compared++;
        if (sample_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL valid_single_pulse: sample_valid=%b one cycle after pulse, required 0", sample_valid);
        end
        dl = 1000; dm = 1000; dr = 1000;
        while (sensor_drive !== 3'b000 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        compared++;
        if ({sensor_drive, filt, raw_bits, count_l, count_m, count_r, sample_valid} !== {3'b000, 3'b111, 3'b111, 54'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL midreset_state: drive=%b filt=%b raw=%b counts=%0d/%0d/%0d valid=%b, required 000 111 111 0/0/0 0",
                     sensor_drive, filt, raw_bits, count_l, count_m, count_r, sample_valid);
        end
        q.delete();
        mf = '{1, 1, 1};
        ms = '{0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sample_valid !== 1'b0 || sensor_drive !== 3'b000) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL midreset_hold: %0d cycles with valid or drive active during reset, required 0", bad);
        end
        dl = 5; dm = 5; dr = 5;
        push_frame(5, 5, 5);
        reset = 1'b0;
        count_charge("midreset");
        wait_sample(cyc);
        compared++;
        if (!sample_valid) begin
            mismatched++;
            $display("FAIL midreset_pulse: no sample_valid within %0d cycles", cyc);
            return;
        end
        e = q.pop_front();
        compared++;
        if (got !== {e.cl, e.cm, e.cr, e.raw, e.filt}) begin
            mismatched++;
            $display("FAIL midreset_frame: counts=%0d/%0d/%0d raw=%b filt=%b, required %0d/%0d/%0d %b %b",
                     count_l, count_m, count_r, raw_bits, filt, e.cl, e.cm, e.cr, e.raw, e.filt);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_pattern();
        test_saturate();
        test_early_end();
        test_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/line_sensor_reader.md
Name: line_sensor_reader

Overview:
- Front end for the line follower: drives three RC-decay reflectance sensors (left, middle, right), times each capacitor discharge, thresholds it, and debounces the result.
- Produces the filtered sensor bits that the motor-steering logic consumes.
- Convention: 1 = bright background (short decay), 0 = dark line (long decay).
- Sits between the top-level tri-state sensor pads and the line-following controller.

Parameters:
- CNT_W, 18, width of the decay counter and count outputs.
- CHARGE_CYCLES, 500, cycles the sensor caps are driven high per frame (10 us at 50 MHz).
- TIMEOUT, 150000, maximum measure cycles; a channel not discharged by then saturates at TIMEOUT.
- THRESHOLD, 50000, a decay count strictly below this gives raw = 1 (bright).
- FILTER_DEPTH, 4, consecutive agreeing frames required to change a filtered bit (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sensor_in  in  3  pad inputs [2]=left [1]=middle [0]=right, asynchronous to clk
- sensor_drive  out  3  pad output-enable; 1 = drive pad high, 0 = release (tri-state done at top level)
- sensorLeftFiltered  out  1  debounced left bit
- sensorMiddleFiltered  out  1  debounced middle bit
- sensorRightFiltered  out  1  debounced right bit
- raw_bits  out  3  undebounced thresholded bits from the last frame
- count_l, count_m, count_r  out  CNT_W  last captured decay counts
- sample_valid  out  1  one-cycle pulse when raw_bits, counts and filtered bits update

Behaviour:
- Reset values (applied asynchronously):
  - sensor_drive = 000
  - filtered bits = 1 (reads as 111, the "stop" pattern)
  - raw_bits = 111
  - counts = 0
  - sample_valid = 0
  - filter streak counters = 0
  - FSM state = CHARGE
- Input synchronisation: sensor_in passes through a 2-flop synchroniser per bit. Measured counts therefore include 2 cycles of synchroniser latency; this is accepted and not compensated.
- FSM states: CHARGE -> MEASURE -> EVAL -> CHARGE. Runs continuously with no idle gap.
- CHARGE:
  - sensor_drive = 111 for exactly CHARGE_CYCLES cycles, then go to MEASURE.
  - The first frame after reset release starts with a full CHARGE.
- MEASURE:
  - sensor_drive = 000. Counter starts at 0 on the first MEASURE cycle and increments by 1 each cycle.
  - Channel i captures the counter value on the first cycle its synchronised input is 0 and sets done[i]. Later input changes within the frame are ignored.
  - Leave MEASURE after the cycle in which all done bits are set, or after the cycle in which counter = TIMEOUT-1, whichever comes first.
  - Any channel not done at that point captures TIMEOUT (saturation, no wrap).
  - Simultaneous discharge on several channels in one cycle: each captures the same value.
- EVAL (1 cycle):
  - raw[i] = (count[i] < THRESHOLD).
  - Each channel's filter is updated with raw[i].
  - Next cycle: raw_bits, count_* and filtered bits become visible with sample_valid = 1 for exactly one cycle.
- Filter, per channel:
  - If raw equals the current filtered value, streak := 0.
  - Otherwise streak := streak+1. When streak reaches FILTER_DEPTH, filtered := raw and streak := 0.
  - FILTER_DEPTH = 1 means filtered follows raw with no extra delay.
- Frame period = CHARGE_CYCLES + measure_cycles + 1.
- Reset mid-frame: sensor_drive drops to 000 immediately, all state returns to reset values, and no partial frame is reported.
- Width rule: TIMEOUT and THRESHOLD must be < 2^CNT_W. The counter never exceeds TIMEOUT-1.

Decomposition:
- Shared package line_sensor_pkg holds:
  - the FSM state encoding (CHARGE, MEASURE, EVAL)
  - default CNT_W / CHARGE_CYCLES / TIMEOUT / THRESHOLD / FILTER_DEPTH constants
  - channel index constants LEFT=2, MIDDLE=1, RIGHT=0
- Sub-module line_sensor_debounce: one per channel, instantiated 3×.
  - Ports: clk, reset, update strobe, raw bit, filtered bit.
  - Parameter FILTER_DEPTH.

Test Plan:
(bench parameters: CHARGE_CYCLES=4, TIMEOUT=100, THRESHOLD=40, FILTER_DEPTH=3)
- Reset then release; hold sensor_in high until MEASURE -> sensor_drive=111 for exactly 4 cycles, then 000; filtered=111 and sample_valid=0 until the first frame completes.
- Sensors drop low 10/60/10 cycles into MEASURE (L/M/R) -> counts 12/62/12 (including sync latency); raw_bits=101; sample_valid pulses once; filtered stays 111 for 2 frames and becomes 101 on the 3rd frame's pulse.
- Middle never discharges -> count_m=100 (saturated); MEASURE lasts exactly 100 cycles; raw_bits[1]=0.
- All three drop at cycle 5 -> MEASURE ends early (frame period ≈ 4+8+1 cycles); counts equal (7,7,7); raw_bits=111.
- Filter glitch: middle raw sequence 0,0,1,0,0,0 starting from filtered=1 -> filtered_m changes to 0 only after the last of three consecutive 0s; the single 1 resets the streak.
- Assert reset mid-MEASURE -> sensor_drive=000 and filtered=111 the same cycle; no sample_valid; after release a clean CHARGE of 4 cycles begins.
